regfile_multi: RTL and testbench

REGFILE_MULTI -- requirements
Module: regfile_multi

---
 rtl/regfile_multi.sv | 98 +++++++++
 tb/tb_regfile_multi.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multi.sv
// Multi-port register file with combinational reads, optional write forwarding,
// optional hardwired zero register and a sequential one-register-per-cycle clear.
module regfile_multi #(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int NREAD    = 2,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ctrl_writeEnable,
    input  logic [AW-1:0]          ctrl_writeReg,
    input  logic [WIDTH-1:0]       data_writeReg,
    input  logic [NREAD*AW-1:0]    ctrl_readReg,
    output logic [NREAD*WIDTH-1:0] data_readReg,
    input  logic                   clear_req,
    output logic                   busy,
    output logic                   write_drop
);

    typedef enum logic {
        IDLE,
        CLEARING
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [AW-1:0]    ptr_q;
    logic [AW-1:0]    ptr_d;
    logic             busy_q;
    logic             drop_q;
    logic             wr_en;

    // A write lands only in IDLE and never on the hardwired zero register.
    assign wr_en = ctrl_writeEnable && (state_q == IDLE) &&
                   !((ZERO_REG != 0) && (ctrl_writeReg == '0));
    assign ptr_d = ptr_q + 1'b1;

    // NOTE: the array is reset explicitly because reset must zero every entry
    // in one cycle; that makes it flops rather than an inferable RAM.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        regs_q[ctrl_writeReg] <= data_writeReg;
                    end
                    if (clear_req) begin
                        state_q <= CLEARING;
                        busy_q  <= 1'b1;
                        ptr_q   <= '0;
                    end
                end
                CLEARING: begin
                    regs_q[ptr_q] <= '0;
                    ptr_q         <= ptr_d;
                    drop_q        <= ctrl_writeEnable;
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [AW-1:0] idx;
        logic          hit_zero;
        logic          fwd;

        assign idx      = ctrl_readReg[k*AW +: AW];
        assign hit_zero = (ZERO_REG != 0) && (idx == '0);
        assign fwd      = (BYPASS != 0) && wr_en && (ctrl_writeReg == idx);
        assign data_readReg[k*WIDTH +: WIDTH] = hit_zero ? '0 :
                                                fwd      ? data_writeReg :
                                                           regs_q[idx];
    end

    assign busy       = busy_q;
    assign write_drop = drop_q;

endmodule

// File: tb/tb_regfile_multi.sv
// Self-checking bench: three regfile_multi configurations driven by directed
// and random stimulus and compared against an array-based reference model.
module tb_regfile_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // Default-parameter pair (bypass on / bypass off) shares one stimulus set.
    logic        we_a, clr_a;
    logic [4:0]  wr_a;
    logic [31:0] wd_a;
    logic [9:0]  rd_a;
    logic [63:0] rdata_a, rdata_n;
    logic        busy_a, drop_a, busy_n, drop_n;
    // Small configuration: WIDTH=16, DEPTH=8, NREAD=4, ZERO_REG=0.
    logic        we_s, clr_s;
    logic [2:0]  wr_s;
    logic [15:0] wd_s;
    logic [11:0] rd_s;
    logic [63:0] rdata_s;
    logic        busy_s, drop_s;

    regfile_multi u_dut (
        .clock(clk), .reset(rst), .ctrl_writeEnable(we_a), .ctrl_writeReg(wr_a),
        .data_writeReg(wd_a), .ctrl_readReg(rd_a), .data_readReg(rdata_a),
        .clear_req(clr_a), .busy(busy_a), .write_drop(drop_a)
    );

    regfile_multi #(.BYPASS(0)) u_nb (
        .clock(clk), .reset(rst), .ctrl_writeEnable(we_a), .ctrl_writeReg(wr_a),
        .data_writeReg(wd_a), .ctrl_readReg(rd_a), .data_readReg(rdata_n),
        .clear_req(clr_a), .busy(busy_n), .write_drop(drop_n)
    );

    regfile_multi #(.WIDTH(16), .DEPTH(8), .NREAD(4), .ZERO_REG(0)) u_small (
        .clock(clk), .reset(rst), .ctrl_writeEnable(we_s), .ctrl_writeReg(wr_s),
        .data_writeReg(wd_s), .ctrl_readReg(rd_s), .data_readReg(rdata_s),
        .clear_req(clr_s), .busy(busy_s), .write_drop(drop_s)
    );

    // Reference model state.
    logic [31:0] m_a [32];
    bit          mclr_a, mdrop_a;
    int          mcnt_a;
    logic [15:0] m_s [8];
    bit          mclr_s, mdrop_s;
    int          mcnt_s;

    int checks;
    int errors;
    int nbusy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_a(input logic [4:0] i, input bit byp);
        if (i == 5'd0) return 32'd0;
        if (byp && we_a && !mclr_a && i == wr_a) return wd_a;
        return m_a[i];
    endfunction

    function automatic logic [15:0] exp_s(input logic [2:0] i);
        if (we_s && !mclr_s && i == wr_s) return wd_s;
        return m_s[i];
    endfunction

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rd_a%0d", k), 64'(rdata_a[k*32 +: 32]), 64'(exp_a(rd_a[k*5 +: 5], 1'b1)));
            check($sformatf("rd_n%0d", k), 64'(rdata_n[k*32 +: 32]), 64'(exp_a(rd_a[k*5 +: 5], 1'b0)));
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rd_s%0d", k), 64'(rdata_s[k*16 +: 16]), 64'(exp_s(rd_s[k*3 +: 3])));
        end
        check("busy_a", 64'(busy_a), 64'(mclr_a));
        check("busy_n", 64'(busy_n), 64'(mclr_a));
        check("drop_a", 64'(drop_a), 64'(mdrop_a));
        check("drop_n", 64'(drop_n), 64'(mdrop_a));
        check("busy_s", 64'(busy_s), 64'(mclr_s));
        check("drop_s", 64'(drop_s), 64'(mdrop_s));
    endtask

    // Advance the model by one rising edge using the inputs held across it.
    task automatic update();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_a[i] = '0;
            for (int i = 0; i < 8; i++)  m_s[i] = '0;
            mclr_a = 0; mdrop_a = 0; mcnt_a = 0;
            mclr_s = 0; mdrop_s = 0; mcnt_s = 0;
        end else begin
            mdrop_a = we_a && mclr_a;
            if (mclr_a) begin
                m_a[mcnt_a] = '0;
                mcnt_a++;
                if (mcnt_a == 32) mclr_a = 0;
            end else begin
                if (we_a && wr_a != 5'd0) m_a[wr_a] = wd_a;
                if (clr_a) begin mclr_a = 1; mcnt_a = 0; end
            end
            mdrop_s = we_s && mclr_s;
            if (mclr_s) begin
                m_s[mcnt_s] = '0;
                mcnt_s++;
                if (mcnt_s == 8) mclr_s = 0;
            end else begin
                if (we_s) m_s[wr_s] = wd_s;
                if (clr_s) begin mclr_s = 1; mcnt_s = 0; end
            end
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        compare();
        @(posedge clk);
        update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0;
        we_a = 0; clr_a = 0; wr_a = '0; wd_a = '0; rd_a = '0;
        we_s = 0; clr_s = 0; wr_s = '0; wd_s = '0; rd_s = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1;
        @(posedge clk);
        update();
        @(negedge clk);
        rst = 0;

        // Every lane reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            rd_a = {5'(31 - i), 5'(i)};
            rd_s = {3'(i), 3'(i + 1), 3'(i + 2), 3'(i + 3)};
            #1;
            check("reset_rd_a", rdata_a, 64'd0);
            check("reset_rd_s", rdata_s, 64'd0);
            cycle();
        end

        // Write r5, read it back on both ports next cycle.
        we_a = 1; wr_a = 5'd5; wd_a = 32'hDEADBEEF; rd_a = '0;
        cycle();
        we_a = 0; rd_a = {5'd5, 5'd5};
        #1;
        check("r5_p0", 64'(rdata_a[31:0]), 64'hDEADBEEF);
        check("r5_p1", 64'(rdata_a[63:32]), 64'hDEADBEEF);
        cycle();

        // Same-cycle forwarding versus old value.
        we_a = 1; wr_a = 5'd7; wd_a = 32'h11; rd_a = '0;
        cycle();
        we_a = 1; wr_a = 5'd7; wd_a = 32'h12345678; rd_a = {5'd7, 5'd0};
        #1;
        check("byp_on", 64'(rdata_a[63:32]), 64'h12345678);
        check("byp_off", 64'(rdata_n[63:32]), 64'h11);
        cycle();

        // Writes to r0 vanish silently.
        we_a = 1; wr_a = 5'd0; wd_a = 32'hFFFFFFFF; rd_a = '0;
        #1;
        check("r0_nobyp", 64'(rdata_a[31:0]), 64'd0);
        cycle();
        we_a = 0;
        #1;
        check("r0_zero", 64'(rdata_a[31:0]), 64'd0);
        check("r0_drop", 64'(drop_a), 64'd0);
        cycle();

        // Without a zero register, r0 holds data on every port.
        we_s = 1; wr_s = 3'd0; wd_s = 16'hBEEF; rd_s = '0;
        cycle();
        we_s = 0;
        #1;
        for (int k = 0; k < 4; k++) check("s_r0", 64'(rdata_s[k*16 +: 16]), 64'hBEEF);
        cycle();

        // Fill with index values, then sweep-clear.
        for (int i = 1; i < 32; i++) begin
            we_a = 1; wr_a = 5'(i); wd_a = 32'(i);
            cycle();
        end
        we_a = 0;
        clr_a = 1;
        cycle();
        clr_a = 0;
        nbusy = 0;
        for (int c = 0; c < 40; c++) begin
            rd_a = {5'd20, 5'd3};
            #1;
            if (busy_a) nbusy++;
            if (c == 9) begin
                check("clr_r3", 64'(rdata_a[31:0]), 64'd0);
                check("clr_r20", 64'(rdata_a[63:32]), 64'd20);
            end
            cycle();
        end
        check("busy_len", 64'(nbusy), 64'd32);
        for (int i = 0; i < 32; i++) begin
            rd_a = {5'(i), 5'(i)};
            #1;
            check("post_clr", rdata_a, 64'd0);
            cycle();
        end

        // Write during a clear is dropped and flagged for one cycle.
        clr_a = 1;
        cycle();
        clr_a = 0;
        cycle();
        cycle();
        we_a = 1; wr_a = 5'd4; wd_a = 32'hA5; rd_a = {5'd4, 5'd4};
        cycle();
        we_a = 0;
        #1;
        check("drop_pulse", 64'(drop_a), 64'd1);
        cycle();
        #1;
        check("drop_once", 64'(drop_a), 64'd0);
        for (int c = 0; c < 35; c++) cycle();
        #1;
        check("r4_after", 64'(rdata_a[31:0]), 64'd0);
        check("busy_done", 64'(busy_a), 64'd0);
        cycle();

        // Reset aborts a clear and beats a simultaneous write and clear_req.
        for (int i = 1; i < 32; i++) begin
            we_a = 1; wr_a = 5'(i); wd_a = $urandom | 32'h1;
            cycle();
        end
        we_a = 0;
        clr_a = 1;
        cycle();
        clr_a = 0;
        for (int c = 0; c < 4; c++) cycle();
        rst = 1; we_a = 1; wr_a = 5'd9; wd_a = 32'h55; clr_a = 1;
        cycle();
        idle_inputs();
        #1;
        check("rst_busy", 64'(busy_a), 64'd0);
        for (int i = 0; i < 32; i++) begin
            rd_a = {5'(i), 5'(i)};
            #1;
            check("rst_rd", rdata_a, 64'd0);
            cycle();
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(99) == 0);
            we_a  = $urandom_range(1);
            wr_a  = 5'($urandom);
            wd_a  = $urandom;
            rd_a  = 10'($urandom);
            clr_a = ($urandom_range(39) == 0);
            we_s  = $urandom_range(1);
            wr_s  = 3'($urandom);
            wd_s  = 16'($urandom);
            rd_s  = 12'($urandom);
            clr_s = ($urandom_range(19) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
